// File: rtl/fpadd_share_ctrl_if.sv
// Bundle of requester, shared-datapath and response signals for fpadd_share_ctrl.
// slave  : controller side.
// master : requester / datapath / consumer side.
interface fpadd_share_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [31:0]      req0_a;
  logic [31:0]      req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [31:0]      req1_a;
  logic [31:0]      req1_b;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic             add_busy;
  logic [31:0]      add_res;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_res;
  logic             rsp_id;
  logic [CNT_W-1:0] op_cnt;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, add_res, rsp_ready,
    output req0_ready, req1_ready, add_a, add_b, add_busy, rsp_valid, rsp_res, rsp_id, op_cnt
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, add_res, rsp_ready,
    input  req0_ready, req1_ready, add_a, add_b, add_busy, rsp_valid, rsp_res, rsp_id, op_cnt
  );
endinterface

// File: rtl/fpadd_share_ctrl.sv
// Round-robin sequencer for a shared combinational FP adder run as a LAT-cycle
// multicycle path. Operands are held in add_a/add_b while the adder settles, the
// sum is captured when the wait counter reaches zero and is returned with the
// requester ID.
// Optional build macro FPADD_ZERO_BYPASS_EN: operations with a +/-0 operand skip
// the adder and respond one cycle after accept.
module fpadd_share_ctrl #(
  parameter int LAT   = 3,   // 1..15
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  fpadd_share_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(LAT - 1);

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [31:0]      add_a_q, add_a_d;
  logic [31:0]      add_b_q, add_b_d;
  logic             add_busy_q, add_busy_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_res_q, rsp_res_d;
  logic             rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;

  logic             grant;
  logic             grant_vld;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic             bypass;
  logic [31:0]      bypass_res;

  // Round-robin pick: a lone requester always wins, a tie goes to the one not served last.
  always_comb begin
    grant_vld = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = bus.req1_valid;
    end
    sel_a = grant ? bus.req1_a : bus.req0_a;
    sel_b = grant ? bus.req1_b : bus.req0_b;
  end

  assign bus.req0_ready = (state_q == IDLE) && grant_vld && !grant;
  assign bus.req1_ready = (state_q == IDLE) && grant_vld &&  grant;

`ifdef FPADD_ZERO_BYPASS_EN
  // Signed-zero shortcut: the sum is the other operand, or a zero whose sign is the AND of both signs.
  always_comb begin
    logic a_zero;
    logic b_zero;
    a_zero = (sel_a[30:0] == 31'd0);
    b_zero = (sel_b[30:0] == 31'd0);
    bypass = a_zero | b_zero;
    if (a_zero && b_zero) begin
      bypass_res = {sel_a[31] & sel_b[31], 31'd0};
    end else if (a_zero) begin
      bypass_res = sel_b;
    end else begin
      bypass_res = sel_a;
    end
  end
`else
  assign bypass     = 1'b0;
  assign bypass_res = 32'd0;
`endif

  // Next-state and output-register logic; everything holds unless a transition updates it.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    add_busy_d   = add_busy_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_res_d    = rsp_res_q;
    rsp_id_d     = rsp_id_q;
    op_cnt_d     = op_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          last_grant_d = grant;
          rsp_id_d     = grant;
          if (bypass) begin
            rsp_res_d   = bypass_res;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else begin
            add_a_d    = sel_a;
            add_b_d    = sel_b;
            wait_cnt_d = WAIT_INIT;
            add_busy_d = 1'b1;
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          rsp_res_d   = bus.add_res;
          add_busy_d  = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_cnt_d    = op_cnt_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      add_a_q      <= 32'd0;
      add_b_q      <= 32'd0;
      add_busy_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_res_q    <= 32'd0;
      rsp_id_q     <= 1'b0;
      op_cnt_q     <= '0;
      wait_cnt_q   <= 4'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      add_busy_q   <= add_busy_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_res_q    <= rsp_res_d;
      rsp_id_q     <= rsp_id_d;
      op_cnt_q     <= op_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_busy  = add_busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_res   = rsp_res_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_fpadd_share_ctrl.sv
// Directed bench for fpadd_share_ctrl: table of operand pairs with hand-computed
// sums, plus sequences for contention, backpressure, mid-op reset and operand
// stability. add_res comes from an FP adder model that can be forced to glitch.
module tb_fpadd_share_ctrl;
  localparam int LAT   = 3;
  localparam int CNT_W = 16;
`ifdef FPADD_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    bit          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;
  logic        glitch_en = 1'b0;
  logic [31:0] glitch_val = 32'd0;
  vec_t        vec [10];

  fpadd_share_ctrl_if #(.CNT_W(CNT_W)) bus ();

  fpadd_share_ctrl #(.LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single -> double for zeros and normals.
  function automatic logic [63:0] sp2dp(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:0] == 31'd0) return {x[31], 63'd0};
    e = {3'b000, x[30:23]} + 11'd896;
    return {x[31], e, x[22:0], 29'd0};
  endfunction

  // Double -> single with round-to-nearest-even.
  function automatic logic [31:0] dp2sp(input logic [63:0] d);
    logic [10:0] e;
    logic [30:0] em;
    logic [28:0] rem;
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e   = d[62:52] - 11'd896;
    em  = {e[7:0], d[51:29]};
    rem = d[28:0];
    if (rem > 29'h10000000 || (rem == 29'h10000000 && em[0])) em = em + 31'd1;
    return {d[63], em};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    real s;
    s = $bitstoreal(sp2dp(a)) + $bitstoreal(sp2dp(b));
    return dp2sp($realtobits(s));
  endfunction

  always_comb bus.add_res = glitch_en ? glitch_val : fp_add(bus.add_a, bus.add_b);

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present an operand pair and wait (bounded) for its ready; returns in the cycle after accept
  // with valid dropped. t is the accept cycle.
  task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b, output int t);
    bit got;
    int n;
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
    end
    #1;
    got = 1'b0;
    n   = 0;
    t   = cyc;
    while (!got && n < 30) begin
      if (id ? bus.req1_ready : bus.req0_ready) begin
        got = 1'b1;
        t   = cyc;
      end
      step();
      n++;
    end
    check("accept", got, 1'b1);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  // Step until rsp_valid (bounded), counting cycles with add_busy high.
  task automatic wait_rsp(output int busy_n);
    busy_n = 0;
    for (int n = 0; n < 40 && !bus.rsp_valid; n++) begin
      if (bus.add_busy) busy_n++;
      step();
    end
  endtask

  initial begin
    int          t;
    int          busy_n;
    int          exp_cnt;
    bit          byp;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    int          ids [4];
    int          ts [4];
    int          got;
    int          guard;

    vec[0] = '{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000}; // 1 + 2 = 3
    vec[1] = '{1'b1, 32'h3FC00000, 32'h40200000, 32'h40800000}; // 1.5 + 2.5 = 4
    vec[2] = '{1'b0, 32'h40A00000, 32'hC0400000, 32'h40000000}; // 5 + -3 = 2
    vec[3] = '{1'b1, 32'h3F000000, 32'h3E800000, 32'h3F400000}; // 0.5 + 0.25 = 0.75
    vec[4] = '{1'b0, 32'h42C80000, 32'h3F800000, 32'h42CA0000}; // 100 + 1 = 101
    vec[5] = '{1'b1, 32'h3F800000, 32'hBF800000, 32'h00000000}; // 1 + -1 = +0
    vec[6] = '{1'b0, 32'h80000000, 32'hC0400000, 32'hC0400000}; // -0 + -3 = -3
    vec[7] = '{1'b1, 32'h80000000, 32'h00000000, 32'h00000000}; // -0 + +0 = +0
    vec[8] = '{1'b0, 32'h40400000, 32'h80000000, 32'h40400000}; // 3 + -0 = 3
    vec[9] = '{1'b1, 32'h80000000, 32'h80000000, 32'h80000000}; // -0 + -0 = -0

    bus.req0_valid = 1'b0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
    bus.req1_valid = 1'b0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
    bus.rsp_ready  = 1'b1;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    check("rst_add_a", bus.add_a, 32'd0);
    check("rst_add_b", bus.add_b, 32'd0);
    check("rst_add_busy", bus.add_busy, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_res", bus.rsp_res, 32'd0);
    check("rst_rsp_id", bus.rsp_id, 1'b0);
    check("rst_op_cnt", bus.op_cnt, 32'd0);
    check("rst_ready0", bus.req0_ready, 1'b0);
    check("rst_ready1", bus.req1_ready, 1'b0);

    // Table-driven single operations
    exp_cnt = 0;
    exp_a   = 32'd0;
    exp_b   = 32'd0;
    for (int i = 0; i < 10; i++) begin
      issue(vec[i].id, vec[i].a, vec[i].b, t);
      byp = BYP && ((vec[i].a[30:0] == 31'd0) || (vec[i].b[30:0] == 31'd0));
      wait_rsp(busy_n);
      check("latency", cyc - t, byp ? 32'd1 : 32'(LAT + 1));
      check("busy_cycles", busy_n, byp ? 32'd0 : 32'(LAT));
      check("rsp_res", bus.rsp_res, vec[i].res);
      check("rsp_id", bus.rsp_id, vec[i].id);
      if (!byp) begin
        exp_a = vec[i].a;
        exp_b = vec[i].b;
      end
      check("add_a_hold", bus.add_a, exp_a);
      check("add_b_hold", bus.add_b, exp_b);
      $display("vec %0d: id=%0d a=%h b=%h res=%h lat=%0d", i, vec[i].id, vec[i].a, vec[i].b,
               bus.rsp_res, cyc - t);
      step();
      exp_cnt++;
      check("rsp_valid_clr", bus.rsp_valid, 1'b0);
      check("op_cnt", bus.op_cnt, 32'(exp_cnt));
    end

    // Contention: both requesters valid from reset
    bus.req0_valid = 1'b1; bus.req0_a = 32'h3F800000; bus.req0_b = 32'h40000000;
    bus.req1_valid = 1'b1; bus.req1_a = 32'h3F000000; bus.req1_b = 32'h3E800000;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    #1;
    got   = 0;
    guard = 0;
    for (int k = 0; k < 4; k++) begin ids[k] = -1; ts[k] = 0; end
    while (got < 4 && guard < 60) begin
      check("one_ready", 32'(bus.req0_ready && bus.req1_ready), 32'd0);
      if (bus.req0_ready || bus.req1_ready) begin
        ids[got] = bus.req1_ready ? 1 : 0;
        ts[got]  = cyc;
        got++;
      end
      step();
      guard++;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("cont_count", got, 32'd4);
    for (int k = 0; k < 4; k++) begin
      check("cont_grant", ids[k], 32'(k % 2));
      if (k > 0) check("cont_interval", ts[k] - ts[k-1], 32'(LAT + 2));
      $display("contention op %0d: grant=%0d cycle=%0d", k, ids[k], ts[k]);
    end
    repeat (LAT + 3) step();
    check("cont_op_cnt", bus.op_cnt, 32'd4);

    // Backpressure: hold the response for 10 cycles
    bus.rsp_ready = 1'b0;
    issue(1'b0, 32'h3F800000, 32'h40000000, t);
    wait_rsp(busy_n);
    check("bp_rsp_valid", bus.rsp_valid, 1'b1);
    bus.req1_valid = 1'b1; bus.req1_a = 32'h3F000000; bus.req1_b = 32'h3E800000;
    #1;
    for (int k = 0; k < 10; k++) begin
      check("bp_hold_valid", bus.rsp_valid, 1'b1);
      check("bp_hold_res", bus.rsp_res, 32'h40400000);
      check("bp_hold_id", bus.rsp_id, 1'b0);
      check("bp_ready0", bus.req0_ready, 1'b0);
      check("bp_ready1", bus.req1_ready, 1'b0);
      check("bp_op_cnt", bus.op_cnt, 32'd4);
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    check("bp_rsp_valid_clr", bus.rsp_valid, 1'b0);
    check("bp_op_cnt_inc", bus.op_cnt, 32'd5);
    check("bp_idle_ready1", bus.req1_ready, 1'b1);
    $display("backpressure: released, op_cnt=%0d", bus.op_cnt);
    step();
    bus.req1_valid = 1'b0;
    wait_rsp(busy_n);
    check("bp_next_res", bus.rsp_res, 32'h3F400000);
    check("bp_next_id", bus.rsp_id, 1'b1);
    step();
    check("bp_next_op_cnt", bus.op_cnt, 32'd6);

    // Reset during WAIT cycle 2
    issue(1'b0, 32'h3F800000, 32'h40000000, t);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mr_add_a", bus.add_a, 32'd0);
    check("mr_add_b", bus.add_b, 32'd0);
    check("mr_add_busy", bus.add_busy, 1'b0);
    check("mr_rsp_valid", bus.rsp_valid, 1'b0);
    check("mr_rsp_res", bus.rsp_res, 32'd0);
    check("mr_rsp_id", bus.rsp_id, 1'b0);
    check("mr_op_cnt", bus.op_cnt, 32'd0);
    for (int k = 0; k < 8; k++) begin
      check("mr_no_rsp", bus.rsp_valid, 1'b0);
      step();
    end
    bus.req0_valid = 1'b1; bus.req0_a = 32'h40A00000; bus.req0_b = 32'hC0400000;
    bus.req1_valid = 1'b1; bus.req1_a = 32'h3F000000; bus.req1_b = 32'h3E800000;
    #1;
    check("mr_first_ready0", bus.req0_ready, 1'b1);
    check("mr_first_ready1", bus.req1_ready, 1'b0);
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_rsp(busy_n);
    check("mr_rsp_id_after", bus.rsp_id, 1'b0);
    check("mr_rsp_res_after", bus.rsp_res, 32'h40000000);
    $display("mid-op reset: first grant after reset id=%0d res=%h", bus.rsp_id, bus.rsp_res);
    step();
    check("mr_op_cnt_after", bus.op_cnt, 32'd1);

    // Operand stability with a glitching adder and moving requester inputs
    issue(1'b0, 32'h40A00000, 32'hC0400000, t);
    for (int k = 1; k <= LAT; k++) begin
      glitch_val = 32'hDEAD0000 + 32'(k);
      glitch_en  = (k != LAT);
      bus.req0_a = 32'h11111111 * 32'(k);
      bus.req0_b = 32'h22222222 * 32'(k);
      check("st_add_a", bus.add_a, 32'h40A00000);
      check("st_add_b", bus.add_b, 32'hC0400000);
      step();
    end
    glitch_en  = 1'b1;
    glitch_val = 32'h12345678;
    check("st_rsp_valid", bus.rsp_valid, 1'b1);
    check("st_rsp_res", bus.rsp_res, 32'h40000000);
    $display("stability: captured res=%h", bus.rsp_res);
    step();
    glitch_en = 1'b0;
    check("st_op_cnt", bus.op_cnt, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fpadd_share_ctrl.md
Name: fpadd_share_ctrl

Overview:
- Sequencing and arbitration controller for the shared single-precision FP add datapath (operand order/align, add/round, normalize).
- The datapath is purely combinational and too deep for one cycle, so it is run as a multicycle path of LAT cycles.
- Two requesters share it through valid/ready handshakes. Round-robin grant; operands are held stable while the datapath settles, the result is captured, and it is returned with a requester ID.

Parameters:
- LAT, 3, cycles the datapath operands are held before add_res is sampled; legal range 1..15.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  controller accepts from requester 0.
- req0_a  in  32  requester 0 operand a, IEEE-754 single.
- req0_b  in  32  requester 0 operand b.
- req1_valid  in  1  requester 1 has an operand pair.
- req1_ready  out  1  controller accepts from requester 1.
- req1_a  in  32  requester 1 operand a.
- req1_b  in  32  requester 1 operand b.
- add_a  out  32  operand a to shared datapath.
- add_b  out  32  operand b to shared datapath.
- add_busy  out  1  datapath operands valid and settling.
- add_res  in  32  datapath sum (combinational from add_a/add_b).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_res  out  32  registered sum.
- rsp_id  out  1  requester that issued the operation.
- op_cnt  out  CNT_W  completed responses, wraps modulo 2^CNT_W.

Behaviour:
- Reset values: state IDLE, last_grant=1 (requester 0 wins first), add_a=add_b=0, add_busy=0, rsp_valid=0, rsp_res=0, rsp_id=0, op_cnt=0, wait counter=0. Reset takes effect at any state; an in-flight operation is dropped with no response.
- States:
  - IDLE: grant logic active.
  - WAIT: datapath settling.
  - RESP: result held.
- Grant in IDLE (combinational):
  - Only one valid: grant that requester.
  - Both valid: grant the requester != last_grant.
  - reqN_ready = (state==IDLE) && grant==N. Both readies are 0 outside IDLE. At most one ready is high per cycle.
- Accept (valid&&ready in IDLE):
  - Register operands into add_a/add_b, rsp_id=grant, last_grant=grant.
  - Set wait counter=LAT-1, add_busy=1, go WAIT.
- WAIT:
  - add_a/add_b are held constant.
  - Counter decrements by 1 per cycle.
  - In the cycle counter==0: capture rsp_res=add_res, add_busy=0, rsp_valid=1, go RESP.
- Latency: accept in cycle T, so rsp_valid first high in cycle T+LAT+1.
- RESP:
  - rsp_valid, rsp_res and rsp_id are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid=0, op_cnt+=1, go IDLE.
  - No accept occurs in the same cycle. Minimum issue interval is LAT+2 cycles.
- add_a/add_b keep their last values in IDLE/RESP; the datapath output is ignored outside the capture cycle.
- Requester inputs are ignored while not ready. A requester that drops valid before ready loses nothing; no grant is recorded.
- op_cnt wraps from 2^CNT_W-1 to 0 without a flag.

Optional Feature:
- Macro: FPADD_ZERO_BYPASS_EN.
- Defined: at accept, if operand a[30:0]==0 or b[30:0]==0, the datapath is skipped. The FSM goes IDLE to RESP directly, with rsp_valid in cycle T+1, add_busy staying 0, and add_a/add_b unchanged. rsp_res is:
  - b when only a is ±0;
  - a when only b is ±0;
  - {a[31]&b[31],31'b0} when both are ±0.
- Undefined: all operations take the WAIT path with latency LAT+1.

Test Plan:
- Bench drives add_res from an ideal FP adder model of add_a/add_b.
- Basic op: req0 a=0x3F800000, b=0x40000000, LAT=3, rsp_ready=1. Expect req0_ready in accept cycle T, add_busy high T+1..T+3, rsp_valid at T+4 with rsp_res=0x40400000, rsp_id=0, op_cnt=1 after.
- Contention: req0 and req1 both valid continuously from reset. Grants alternate 0,1,0,1 over 4 ops, and each accept is separated by exactly LAT+2=5 cycles.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid. rsp_res/rsp_id stay stable, both readies stay 0, op_cnt is unchanged. On rsp_ready=1, one handshake occurs, then state is IDLE the next cycle.
- Reset mid-op: assert rst in WAIT cycle 2. Next cycle all outputs are at reset values, no rsp_valid ever appears for the dropped op, and the next contention grants req0 first.
- Operand stability: change add_res model glitches plus req0_a during WAIT. add_a/add_b stay constant, and the captured value equals add_res in the counter==0 cycle only.
- Bypass (FPADD_ZERO_BYPASS_EN): a=0x80000000, b=0xC0400000 gives rsp_valid at T+1, rsp_res=0xC0400000, add_busy never high. a=0x80000000, b=0x00000000 gives rsp_res=0x00000000.
